// File: rtl/rv_branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv_branch_predictor_if
//  Description : Fetch lookup, EXECUTE resolution and statistics signals of
//                the branch predictor, bundled for the predictor port.
//  Revision    : 1.0  initial release
// ============================================================================
interface rv_branch_predictor_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    // Fetch-side lookup
    logic [PC_WIDTH-1:0]  i_fetch_pc;
    logic                 o_pred_taken;
    logic [PC_WIDTH-1:0]  o_pred_target;

    // EXECUTE-side resolution / training
    logic                 i_upd_valid;
    logic [PC_WIDTH-1:0]  i_upd_pc;
    logic                 i_upd_is_branch;
    logic                 i_upd_is_jump;
    logic                 i_upd_taken;
    logic [PC_WIDTH-1:0]  i_upd_target;
    logic                 i_upd_pred_taken;
    logic [PC_WIDTH-1:0]  i_upd_pred_target;
    logic                 i_invalidate;

    // Flush / redirect and statistics
    logic                 o_mispredict;
    logic [PC_WIDTH-1:0]  o_correct_pc;
    logic [CNT_WIDTH-1:0] o_branch_count;
    logic [CNT_WIDTH-1:0] o_mispredict_count;

    // Core pipeline side: drives lookup PC and resolution info
    modport master (
        output i_fetch_pc,
        input  o_pred_taken, o_pred_target,
        output i_upd_valid, i_upd_pc, i_upd_is_branch, i_upd_is_jump,
        output i_upd_taken, i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        output i_invalidate,
        input  o_mispredict, o_correct_pc, o_branch_count, o_mispredict_count
    );

    // Predictor side
    modport slave (
        input  i_fetch_pc,
        output o_pred_taken, o_pred_target,
        input  i_upd_valid, i_upd_pc, i_upd_is_branch, i_upd_is_jump,
        input  i_upd_taken, i_upd_target, i_upd_pred_taken, i_upd_pred_target,
        input  i_invalidate,
        output o_mispredict, o_correct_pc, o_branch_count, o_mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/rv_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : rv_branch_predictor
//  Description : Direct-mapped BTB with per-entry saturating direction
//                counters. Supplies the next fetch PC, is trained from
//                EXECUTE, flags mispredicts and keeps saturating statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int PC_WIDTH  = 32,
    parameter int CTR_BITS  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    rv_branch_predictor_if.slave bp
);

    localparam int c_IDX   = $clog2(ENTRIES);
    localparam int c_TAG_W = PC_WIDTH - c_IDX - 2;

    // Counter encodings: weakly taken is the MSB alone, weakly not-taken one below
    localparam logic [CTR_BITS-1:0]  c_WT       = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0]  c_WNT      = c_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0]  c_CTR_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
    localparam logic [PC_WIDTH-1:0]  c_PC_STEP  = PC_WIDTH'(4);

    // ------------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------------
    logic                  r_valid  [ENTRIES];
    logic [c_TAG_W-1:0]    r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0]   r_target [ENTRIES];
    logic                  r_jump   [ENTRIES];
    logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];

    logic [CNT_WIDTH-1:0]  r_branch_count;
    logic [CNT_WIDTH-1:0]  r_mispredict_count;

    // ------------------------------------------------------------------------
    // Lookup (fetch side), zero latency, reads pre-update contents
    // ------------------------------------------------------------------------
    logic [c_IDX-1:0]   w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic               w_lk_hit;
    logic               w_lk_taken;

    assign w_lk_idx   = bp.i_fetch_pc[c_IDX+1:2];
    assign w_lk_tag   = bp.i_fetch_pc[PC_WIDTH-1:c_IDX+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    // Jumps always redirect; branches follow the counter MSB
    assign w_lk_taken = w_lk_hit && (r_jump[w_lk_idx] || r_ctr[w_lk_idx][CTR_BITS-1]);

    assign bp.o_pred_taken  = w_lk_taken;
    assign bp.o_pred_target = w_lk_taken ? r_target[w_lk_idx]
                                         : bp.i_fetch_pc + c_PC_STEP;

    // ------------------------------------------------------------------------
    // Update (EXECUTE side)
    // ------------------------------------------------------------------------
    logic [c_IDX-1:0]   w_up_idx;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_up_hit;
    logic               w_up_ctrl;
    logic               w_up_active;
    logic               w_up_alias;
    logic               w_mispredict;

    assign w_up_idx    = bp.i_upd_pc[c_IDX+1:2];
    assign w_up_tag    = bp.i_upd_pc[PC_WIDTH-1:c_IDX+2];
    assign w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctrl   = bp.i_upd_is_branch || bp.i_upd_is_jump;
    assign w_up_active = bp.i_upd_valid && w_up_ctrl;
    // A non-control instruction that hits means an alias entry predicted it
    assign w_up_alias  = bp.i_upd_valid && !w_up_ctrl && w_up_hit;

    // Mispredict is a pure function of the resolution inputs, no table read
    assign w_mispredict = bp.i_upd_valid &&
                          ((bp.i_upd_taken != bp.i_upd_pred_taken) ||
                           (bp.i_upd_taken && (bp.i_upd_target != bp.i_upd_pred_target)) ||
                           (!w_up_ctrl && bp.i_upd_pred_taken));

    assign bp.o_mispredict       = w_mispredict;
    assign bp.o_correct_pc       = bp.i_upd_taken ? bp.i_upd_target
                                                  : bp.i_upd_pc + c_PC_STEP;
    assign bp.o_branch_count     = r_branch_count;
    assign bp.o_mispredict_count = r_mispredict_count;

    // Table training, alias clean-up and invalidate (invalidate has last word)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_jump[i]   <= 1'b0;
                r_ctr[i]    <= c_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_up_idx == c_IDX'(i)) begin
                    if (w_up_active) begin
                        if (w_up_hit) begin
                            r_jump[i] <= bp.i_upd_is_jump;
                            if (bp.i_upd_taken) begin
                                r_target[i] <= bp.i_upd_target;
                                if (r_ctr[i] != c_CTR_MAX) begin
                                    r_ctr[i] <= r_ctr[i] + CTR_BITS'(1);
                                end
                            end else if (r_ctr[i] != '0) begin
                                r_ctr[i] <= r_ctr[i] - CTR_BITS'(1);
                            end
                        end else if (bp.i_upd_taken) begin
                            // Allocate, replacing whatever occupied the slot
                            r_valid[i]  <= 1'b1;
                            r_tag[i]    <= w_up_tag;
                            r_target[i] <= bp.i_upd_target;
                            r_jump[i]   <= bp.i_upd_is_jump;
                            r_ctr[i]    <= c_WT;
                        end
                    end
                    if (w_up_alias) begin
                        r_valid[i] <= 1'b0;
                    end
                end
                if (bp.i_invalidate) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating statistics, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_up_active && (r_branch_count != c_CNT_MAX)) begin
                r_branch_count <= r_branch_count + CNT_WIDTH'(1);
            end
            if (w_mispredict && (r_mispredict_count != c_CNT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_branch_predictor
//  Description : Directed bench for rv_branch_predictor with a queue-based
//                scoreboard; stimulus pushes expectations, a monitor pops
//                and compares them against the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_branch_predictor;

    localparam int ENTRIES   = 16;
    localparam int PC_WIDTH  = 32;
    localparam int CTR_BITS  = 2;
    localparam int CNT_WIDTH = 4;

    localparam int SEL_PTAKEN = 0;
    localparam int SEL_PTGT   = 1;
    localparam int SEL_MP     = 2;
    localparam int SEL_CPC    = 3;
    localparam int SEL_BCNT   = 4;
    localparam int SEL_MCNT   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rv_branch_predictor_if #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bp_if ();

    rv_branch_predictor #(
        .ENTRIES  (ENTRIES),
        .PC_WIDTH (PC_WIDTH),
        .CTR_BITS (CTR_BITS),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp_if)
    );

    int total = 0;
    int bad   = 0;

    string       q_name [$];
    int          q_sel  [$];
    logic [31:0] q_exp  [$];
    event        chk_ev;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            SEL_PTAKEN: return 32'(bp_if.o_pred_taken);
            SEL_PTGT:   return bp_if.o_pred_target;
            SEL_MP:     return 32'(bp_if.o_mispredict);
            SEL_CPC:    return bp_if.o_correct_pc;
            SEL_BCNT:   return 32'(bp_if.o_branch_count);
            default:    return 32'(bp_if.o_mispredict_count);
        endcase
    endfunction

    // Monitor: drains the expectation queue whenever a sample is presented
    initial begin
        string       n;
        int          s;
        logic [31:0] e;
        logic [31:0] a;
        forever begin
            @(chk_ev);
            while (q_sel.size() > 0) begin
                n = q_name.pop_front();
                s = q_sel.pop_front();
                e = q_exp.pop_front();
                a = observe(s);
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", n, a, e, $time);
                end
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] e);
        q_name.push_back(n);
        q_sel.push_back(sel);
        q_exp.push_back(e);
    endtask

    task automatic sample();
        -> chk_ev;
        #1;
        if (q_sel.size() != 0) begin
            total++;
            bad++;
            $display("FAIL monitor_drain: pending=%0d, required=0", q_sel.size());
            q_name.delete();
            q_sel.delete();
            q_exp.delete();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bp_if.i_upd_valid       = 1'b0;
        bp_if.i_upd_pc          = '0;
        bp_if.i_upd_is_branch   = 1'b0;
        bp_if.i_upd_is_jump     = 1'b0;
        bp_if.i_upd_taken       = 1'b0;
        bp_if.i_upd_target      = '0;
        bp_if.i_upd_pred_taken  = 1'b0;
        bp_if.i_upd_pred_target = '0;
        bp_if.i_invalidate      = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic br, input logic jp,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        bp_if.i_upd_valid       = 1'b1;
        bp_if.i_upd_pc          = pc;
        bp_if.i_upd_is_branch   = br;
        bp_if.i_upd_is_jump     = jp;
        bp_if.i_upd_taken       = tk;
        bp_if.i_upd_target      = tgt;
        bp_if.i_upd_pred_taken  = ptk;
        bp_if.i_upd_pred_target = ptgt;
        bp_if.i_invalidate      = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Training pattern T,T,N,N,N starting from the allocated weakly-taken state
    logic        tr_tk   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tr_pre  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        tr_post [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tr_mp   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        bp_if.i_fetch_pc = 32'h40;
        idle();
        rst_n = 1'b0;
        #2;
        expect_val("rst_pred_taken", SEL_PTAKEN, 32'h0);
        expect_val("rst_pred_target", SEL_PTGT, 32'h44);
        expect_val("rst_mispredict", SEL_MP, 32'h0);
        expect_val("rst_branch_count", SEL_BCNT, 32'h0);
        expect_val("rst_mp_count", SEL_MCNT, 32'h0);
        sample();
        rst_n = 1'b1;

        // First taken branch: mispredicts, allocates
        cyc();
        upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        expect_val("first_mispredict", SEL_MP, 32'h1);
        expect_val("first_correct_pc", SEL_CPC, 32'h20);
        expect_val("no_bypass_pred", SEL_PTAKEN, 32'h0);
        sample();
        cyc();
        idle();
        expect_val("alloc_pred_taken", SEL_PTAKEN, 32'h1);
        expect_val("alloc_pred_target", SEL_PTGT, 32'h20);
        expect_val("alloc_branch_count", SEL_BCNT, 32'h1);
        expect_val("alloc_mp_count", SEL_MCNT, 32'h1);
        sample();

        // Counter training 2 -> 3,3,2,1,0
        for (int k = 0; k < 5; k++) begin
            cyc();
            upd(32'h40, 1'b1, 1'b0, tr_tk[k], 32'h20, tr_pre[k],
                tr_pre[k] ? 32'h20 : 32'h44);
            expect_val($sformatf("train%0d_mispredict", k), SEL_MP, 32'(tr_mp[k]));
            sample();
            cyc();
            idle();
            expect_val($sformatf("train%0d_pred", k), SEL_PTAKEN, 32'(tr_post[k]));
            sample();
        end
        expect_val("train_branch_count", SEL_BCNT, 32'd6);
        expect_val("train_mp_count", SEL_MCNT, 32'd3);
        sample();

        // Conflict: 0x80 shares the slot with 0x40 and replaces it
        cyc();
        upd(32'h80, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h84);
        expect_val("conflict_mispredict", SEL_MP, 32'h1);
        sample();
        cyc();
        idle();
        expect_val("conflict_0x40_miss", SEL_PTAKEN, 32'h0);
        expect_val("conflict_0x40_target", SEL_PTGT, 32'h44);
        sample();
        bp_if.i_fetch_pc = 32'h80;
        expect_val("conflict_0x80_hit", SEL_PTAKEN, 32'h1);
        expect_val("conflict_0x80_target", SEL_PTGT, 32'h300);
        sample();

        // JAL at 0x100, then drive its counter down to 0
        cyc();
        upd(32'h100, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h104);
        expect_val("jal_mispredict", SEL_MP, 32'h1);
        sample();
        for (int k = 0; k < 2; k++) begin
            cyc();
            upd(32'h100, 1'b0, 1'b1, 1'b0, 32'h500, 1'b0, 32'h104);
            expect_val($sformatf("jal_dec%0d_mispredict", k), SEL_MP, 32'h0);
            sample();
        end
        cyc();
        idle();
        bp_if.i_fetch_pc = 32'h100;
        expect_val("jal_ctr0_pred_taken", SEL_PTAKEN, 32'h1);
        expect_val("jal_ctr0_pred_target", SEL_PTGT, 32'h500);
        sample();

        // Alias clean-up on a non-control instruction hitting 0x80
        cyc();
        upd(32'h80, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h84);
        sample();
        cyc();
        upd(32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        bp_if.i_fetch_pc = 32'h80;
        expect_val("alias_mispredict", SEL_MP, 32'h1);
        expect_val("alias_correct_pc", SEL_CPC, 32'h84);
        expect_val("alias_pre_pred", SEL_PTAKEN, 32'h1);
        sample();
        cyc();
        idle();
        expect_val("alias_cleared_pred", SEL_PTAKEN, 32'h0);
        expect_val("alias_cleared_target", SEL_PTGT, 32'h84);
        expect_val("alias_branch_count", SEL_BCNT, 32'd11);
        expect_val("alias_mp_count", SEL_MCNT, 32'd7);
        sample();

        // Invalidate wins over a same-cycle allocation
        cyc();
        upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
        bp_if.i_invalidate = 1'b1;
        expect_val("inval_mispredict", SEL_MP, 32'h0);
        sample();
        cyc();
        idle();
        bp_if.i_fetch_pc = 32'h40;
        expect_val("inval_pred_taken", SEL_PTAKEN, 32'h0);
        expect_val("inval_pred_target", SEL_PTGT, 32'h44);
        expect_val("inval_branch_count", SEL_BCNT, 32'd12);
        expect_val("inval_mp_count", SEL_MCNT, 32'd7);
        sample();

        // Statistics saturation with 20 mispredicting branches
        for (int k = 0; k < 20; k++) begin
            cyc();
            upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h204);
        end
        cyc();
        idle();
        bp_if.i_fetch_pc = 32'h200;
        expect_val("sat_branch_count", SEL_BCNT, 32'd15);
        expect_val("sat_mp_count", SEL_MCNT, 32'd15);
        expect_val("sat_pred_taken", SEL_PTAKEN, 32'h1);
        expect_val("sat_pred_target", SEL_PTGT, 32'h700);
        sample();

        // Asynchronous reset in the middle of an update
        cyc();
        upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h204);
        #1;
        rst_n = 1'b0;
        #1;
        expect_val("arst_pred_taken", SEL_PTAKEN, 32'h0);
        expect_val("arst_pred_target", SEL_PTGT, 32'h204);
        expect_val("arst_mispredict_upd", SEL_MP, 32'h1);
        expect_val("arst_correct_pc", SEL_CPC, 32'h700);
        expect_val("arst_branch_count", SEL_BCNT, 32'h0);
        expect_val("arst_mp_count", SEL_MCNT, 32'h0);
        sample();
        idle();
        rst_n = 1'b1;
        cyc();
        expect_val("post_rst_pred_taken", SEL_PTAKEN, 32'h0);
        expect_val("post_rst_mispredict", SEL_MP, 32'h0);
        expect_val("post_rst_branch_count", SEL_BCNT, 32'h0);
        sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
